sll_iter: RTL and testbench

SLL_ITER -- requirements
Module: sll_iter

---
 rtl/sll_iter_if.sv | 37 +++
 rtl/sll_iter.sv | 134 +++++++++++++
 tb/tb_sll_iter.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/sll_iter_if.sv
`default_nettype none
// ============================================================================
// Module      : sll_iter_if
// Description : Request/result bundle for the iterative 16-bit shifter.
//               Master drives the request, slave returns result and status.
// Revision    : 1.0 - initial release
// ============================================================================
interface sll_iter_if;
  logic        start;
  logic [15:0] in;
  logic [3:0]  cnt;
  logic        rot;
  logic [15:0] out;
  logic        busy;
  logic        done;

  modport master (
    output start,
    output in,
    output cnt,
    output rot,
    input  out,
    input  busy,
    input  done
  );

  modport slave (
    input  start,
    input  in,
    input  cnt,
    input  rot,
    output out,
    output busy,
    output done
  );
endinterface
`default_nettype wire

// File: rtl/sll_iter.sv
`default_nettype none
// ============================================================================
// Module      : sll_iter
// Description : Iterative 16-bit shift-left-logical / rotate-left unit.
//               One barrel stage (1, 2, 4, 8) is applied per SHIFT cycle,
//               giving a fixed 4-cycle latency followed by a 1-cycle done.
// Revision    : 1.0 - initial release
// ============================================================================
module sll_iter (
  input  logic     clk,
  input  logic     rst,
  sll_iter_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic        w_accept;

  logic [1:0]  r_stg;
  logic [15:0] r_work;
  logic [3:0]  r_cnt;
  logic        r_rot;
  logic [15:0] r_out;

  logic        w_en;
  logic [15:0] w_shl;
  logic [15:0] w_rol;
  logic [15:0] w_stage;

  // State register; reset wins over every transition.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic; a request is only taken when not busy.
  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          w_accept     = 1'b1;
          w_next_state = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (r_stg == 2'd3) begin
          w_next_state = ST_DONE;
        end
      end
      ST_DONE: begin
        if (bus.start) begin
          w_accept     = 1'b1;
          w_next_state = ST_SHIFT;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // Current barrel stage: distance 2**stg, enabled by the matching cnt bit.
  always_comb begin
    w_en  = r_cnt[r_stg];
    w_shl = r_work;
    w_rol = r_work;
    case (r_stg)
      2'd0: begin
        w_shl = {r_work[14:0], 1'b0};
        w_rol = {r_work[14:0], r_work[15]};
      end
      2'd1: begin
        w_shl = {r_work[13:0], 2'b00};
        w_rol = {r_work[13:0], r_work[15:14]};
      end
      2'd2: begin
        w_shl = {r_work[11:0], 4'h0};
        w_rol = {r_work[11:0], r_work[15:12]};
      end
      default: begin
        w_shl = {r_work[7:0], 8'h00};
        w_rol = {r_work[7:0], r_work[15:8]};
      end
    endcase
    if (!w_en) begin
      w_stage = r_work;
    end else if (r_rot) begin
      w_stage = w_rol;
    end else begin
      w_stage = w_shl;
    end
  end

  // Operand latch, stage iteration and result register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_stg  <= 2'd0;
      r_work <= 16'h0000;
      r_cnt  <= 4'h0;
      r_rot  <= 1'b0;
      r_out  <= 16'h0000;
    end else if (w_accept) begin
      r_stg  <= 2'd0;
      r_work <= bus.in;
      r_cnt  <= bus.cnt;
      r_rot  <= bus.rot;
    end else if (r_state == ST_SHIFT) begin
      r_work <= w_stage;
      r_stg  <= r_stg + 2'd1;
      if (r_stg == 2'd3) begin
        r_out <= w_stage;
      end
    end
  end

  assign bus.out  = r_out;
  assign bus.busy = (r_state == ST_SHIFT);
  assign bus.done = (r_state == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_sll_iter.sv
`default_nettype none
// ============================================================================
// Module      : tb_sll_iter
// Description : Directed self-checking bench for sll_iter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sll_iter;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  logic [15:0] exp_out;

  sll_iter_if u_if ();

  sll_iter u_dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_status(input string tag, input logic b, input logic d);
    chk({tag, "_busy"}, {15'd0, u_if.busy}, {15'd0, b});
    chk({tag, "_done"}, {15'd0, u_if.done}, {15'd0, d});
  endtask

  // Issue one request with start pulsed for a single edge and follow it
  // through busy, done and the return to idle.
  task automatic run_op(input string tag, input logic [15:0] a,
                        input logic [3:0] c, input logic r, input logic [15:0] res);
    u_if.in    = a;
    u_if.cnt   = c;
    u_if.rot   = r;
    u_if.start = 1'b1;
    tick();
    u_if.start = 1'b0;
    u_if.in    = ~a;
    u_if.cnt   = ~c;
    u_if.rot   = ~r;
    for (int i = 0; i < 4; i++) begin
      chk_status({tag, "_shift"}, 1'b1, 1'b0);
      chk({tag, "_hold"}, u_if.out, exp_out);
      if (i < 3) tick();
    end
    tick();
    exp_out = res;
    chk_status({tag, "_fin"}, 1'b0, 1'b1);
    chk({tag, "_out"}, u_if.out, exp_out);
    tick();
    chk_status({tag, "_idle"}, 1'b0, 1'b0);
    chk({tag, "_keep"}, u_if.out, exp_out);
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    exp_out    = 16'h0000;
    rst        = 1'b0;
    u_if.start = 1'b1;
    u_if.in    = 16'hDEAD;
    u_if.cnt   = 4'h3;
    u_if.rot   = 1'b0;

    // Reset has priority over a pending start.
    tick();
    tick();
    chk_status("reset", 1'b0, 1'b0);
    chk("reset_out", u_if.out, 16'h0000);

    // Start sampled on the first edge after release.
    rst = 1'b1;
    run_op("sll_max", 16'h0001, 4'd15, 1'b0, 16'h8000);

    run_op("sll4",  16'hABCD, 4'd4, 1'b0, 16'hBCD0);
    run_op("rol4",  16'hABCD, 4'd4, 1'b1, 16'hBCDA);
    run_op("rol1",  16'h8001, 4'd1, 1'b1, 16'h0003);
    run_op("sll1",  16'h8001, 4'd1, 1'b0, 16'h0002);
    run_op("rol0",  16'h5A5A, 4'd0, 1'b1, 16'h5A5A);
    run_op("sll0",  16'hA5A5, 4'd0, 1'b0, 16'hA5A5);
    run_op("mix",   16'h1234, 4'd7, 1'b1, 16'h1A09);

    // Start while busy is dropped.
    u_if.in    = 16'h1234;
    u_if.cnt   = 4'd0;
    u_if.rot   = 1'b0;
    u_if.start = 1'b1;
    tick();                       // E0
    u_if.start = 1'b0;
    tick();                       // E1
    u_if.start = 1'b1;
    u_if.in    = 16'hFFFF;
    u_if.cnt   = 4'd8;
    tick();                       // E2
    u_if.start = 1'b0;
    chk_status("busy_drop_e2", 1'b1, 1'b0);
    tick();                       // E3
    tick();                       // E4
    exp_out = 16'h1234;
    chk_status("busy_drop_fin", 1'b0, 1'b1);
    chk("busy_drop_out", u_if.out, exp_out);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk_status("busy_drop_after", 1'b0, 1'b0);
      chk("busy_drop_keep", u_if.out, exp_out);
    end

    // Back-to-back with start held: done every 5 cycles, never idle.
    u_if.in    = 16'h0F0F;
    u_if.cnt   = 4'd4;
    u_if.rot   = 1'b1;
    u_if.start = 1'b1;
    for (int k = 0; k < 15; k++) begin
      tick();
      chk_status("b2b", (k % 5) != 4, (k % 5) == 4);
      if ((k % 5) == 4) begin
        exp_out = 16'hF0F0;
        chk("b2b_out", u_if.out, exp_out);
      end
    end
    u_if.start = 1'b0;
    tick();
    chk_status("b2b_end", 1'b0, 1'b0);

    // Reset in the middle of an operation aborts it.
    u_if.in    = 16'h00FF;
    u_if.cnt   = 4'd4;
    u_if.rot   = 1'b0;
    u_if.start = 1'b1;
    tick();                       // E0
    u_if.start = 1'b0;
    tick();                       // E1
    rst = 1'b0;
    tick();                       // E2
    exp_out = 16'h0000;
    chk_status("abort", 1'b0, 1'b0);
    chk("abort_out", u_if.out, exp_out);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_status("abort_after", 1'b0, 1'b0);
      chk("abort_keep", u_if.out, exp_out);
    end
    run_op("post_abort", 16'h00FF, 4'd4, 1'b0, 16'h0FF0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
